// File: rtl/cd_spi_slave_if.sv
// ---------------------------------------------------------------------------
// cd_spi_slave_if
//   CDBUS CSR bus as seen between the SPI bridge and the CSR register file.
//
//   Signals
//     csr_address    5  register address, held stable between strobes
//     csr_read       1  one-clk read commit strobe
//     csr_readdata   8  read data, combinational from csr_address
//     csr_write      1  one-clk write strobe
//     csr_writedata  8  write data, valid while csr_write is high
//
//   Modports
//     master  the bridge (drives address and strobes)
//     slave   the register file (drives read data)
// ---------------------------------------------------------------------------
interface cd_spi_slave_if;
    logic [4:0] csr_address;
    logic       csr_read;
    logic [7:0] csr_readdata;
    logic       csr_write;
    logic [7:0] csr_writedata;

    modport master (
        output csr_address,
        output csr_read,
        output csr_write,
        output csr_writedata,
        input  csr_readdata
    );

    modport slave (
        input  csr_address,
        input  csr_read,
        input  csr_write,
        input  csr_writedata,
        output csr_readdata
    );
endinterface

// File: rtl/cd_spi_slave.sv
// ---------------------------------------------------------------------------
// cd_spi_slave
//   SPI slave (mode 0, MSB first) bridging an external host MCU onto the
//   8-bit CDBUS CSR bus. One header byte followed by any number of data
//   bytes is exchanged per spi_ss_n low period. All SPI pins are
//   oversampled in clk, so SCLK must stay at or below clk/8.
//
//   Header byte: b7 = write, b6 = address increment, b5 ignored,
//                b4:0 = start CSR address.
//
//   Reads use peek-then-commit: the outgoing byte is loaded from
//   csr_readdata without a strobe, and csr_read is only pulsed when the
//   host clocks the first bit of that byte. A side-effect register
//   (e.g. an RX window) therefore only advances for bytes the host
//   actually takes.
//
//   Build option
//     CD_SPI_ADDR_INC_EN  defined: header inc=1 makes the address step by
//                         one (5-bit wrap) after every read commit or
//                         write. Undefined: the address is fixed for the
//                         whole burst regardless of inc.
//
//   Parameters
//     SYNC_STAGES  synchronizer depth on sclk/ss_n/mosi (>= 2)
//
//   Ports
//     clk          system clock
//     reset_n      synchronous active-low reset
//     spi_sclk     SPI clock (asynchronous to clk)
//     spi_ss_n     SPI chip select, active-low
//     spi_mosi     host-to-slave data
//     spi_miso     slave-to-host data
//     spi_miso_oe  miso pad output enable
//     csr          CSR bus, master side
// ---------------------------------------------------------------------------
module cd_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_sclk,
    input  logic                  spi_ss_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    cd_spi_slave_if.master        csr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;

    // Synchronizers; the oldest bit of each vector is the synced value.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;

    // Set once ss_n has been seen high; a header is only recognized after
    // the host has deasserted select at least once since reset.
    logic       armed;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] rx_next;
    logic [7:0] tx_sr;
    logic       wr_mode;
    logic       load_pend;

    logic [4:0] addr_q;
    logic       read_q;
    logic       write_q;
    logic [7:0] wdata_q;
    logic       miso_q;
    logic       oe_q;

`ifdef CD_SPI_ADDR_INC_EN
    logic inc_mode;
    // Address steps one clk after the strobe so the register file sees a
    // stable address during the strobe itself.
    logic adv_pend;
`endif

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    // Byte as it will look after the current rise has shifted mosi in.
    assign rx_next = {rx_sr, mosi_s};

    assign csr.csr_address   = addr_q;
    assign csr.csr_read      = read_q;
    assign csr.csr_write     = write_q;
    assign csr.csr_writedata = wdata_q;
    assign spi_miso          = miso_q;
    assign spi_miso_oe       = oe_q;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values; blocking assignments would let
    // later statements see half-updated state and break the shift chains.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            armed     <= 1'b0;
            bit_cnt   <= 3'd0;
            rx_sr     <= 7'd0;
            tx_sr     <= 8'd0;
            wr_mode   <= 1'b0;
            load_pend <= 1'b0;
            addr_q    <= 5'd0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= 8'd0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
`ifdef CD_SPI_ADDR_INC_EN
            inc_mode  <= 1'b0;
            adv_pend  <= 1'b0;
`endif
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;

            // NOTE: strobes default low every clk and are only raised by the
            // branches below, which keeps them exactly one clk wide.
            read_q  <= 1'b0;
            write_q <= 1'b0;

`ifdef CD_SPI_ADDR_INC_EN
            if (adv_pend) begin
                adv_pend <= 1'b0;
                if (inc_mode) begin
                    addr_q <= addr_q + 5'd1;
                end
            end
`endif

            if (ss_s) begin
                // Select released: drop any partial byte, no strobe.
                state     <= IDLE;
                armed     <= 1'b1;
                bit_cnt   <= 3'd0;
                load_pend <= 1'b0;
                miso_q    <= 1'b0;
                oe_q      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (armed) begin
                            state   <= HDR;
                            bit_cnt <= 3'd0;
                            miso_q  <= 1'b0;
                            oe_q    <= 1'b1;
                        end
                    end

                    HDR: begin
                        if (sclk_rise) begin
                            rx_sr   <= rx_next[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                wr_mode   <= rx_next[7];
                                addr_q    <= rx_next[4:0];
`ifdef CD_SPI_ADDR_INC_EN
                                inc_mode  <= rx_next[6];
`endif
                                // Peek one clk later, once csr_address
                                // carries the new header address.
                                load_pend <= 1'b1;
                                state     <= DATA;
                            end
                        end
                    end

                    DATA: begin
                        if (load_pend) begin
                            load_pend <= 1'b0;
                            if (!wr_mode) begin
                                tx_sr <= csr.csr_readdata;
                            end
                        end

                        if (sclk_rise) begin
                            rx_sr   <= rx_next[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (wr_mode) begin
                                if (bit_cnt == 3'd7) begin
                                    wdata_q  <= rx_next;
                                    write_q  <= 1'b1;
`ifdef CD_SPI_ADDR_INC_EN
                                    adv_pend <= 1'b1;
`endif
                                end
                            end else begin
                                // First host rise of a byte commits the
                                // read of the byte already being shifted.
                                if (bit_cnt == 3'd0) begin
                                    read_q   <= 1'b1;
`ifdef CD_SPI_ADDR_INC_EN
                                    adv_pend <= 1'b1;
`endif
                                end
                                if (bit_cnt == 3'd7) begin
                                    load_pend <= 1'b1;
                                end
                            end
                        end

                        // SCLK <= clk/8 guarantees a fall never lands on the
                        // clk that performs a peek load.
                        if (sclk_fall && !wr_mode) begin
                            miso_q <= tx_sr[7];
                            tx_sr  <= {tx_sr[6:0], 1'b0};
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
